// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for pipelined_adder: segment-width derivation, parameter
// legality check and the per-stage control bundle.
package pipelined_adder_pkg;

    // Bits handled by one ripple segment.
    function automatic int unsigned seg_width(input int unsigned width,
                                              input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

    // Control half of a stage register; the top adds the WIDTH-sized data fields.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple segment; also exposes the carry into its
// most significant bit so the top can derive signed overflow.
module adder_seg
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           carry_i,
    output logic [SEG-1:0] sum,
    output logic           carry_o,
    output logic           carry_msb_o
);

    always_comb begin
        logic c;
        // NOTE: blocking assignments in combinational logic so each bit sees
        // the carry just computed by the bit below it within the same pass.
        c   = carry_i;
        sum = '0;
        for (int i = 0; i < SEG; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_o     = c;
        carry_msb_o = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES registered ripple segments with a
// valid/ready handshake. Define PIPELINED_ADDER_OVF_EN to add overflow_o.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             overflow_o,
`endif
    output logic             carry_o
);

    localparam int unsigned SEG = seg_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Operand fields travel whole; only the not-yet-added segments matter.
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    logic   adv;

    logic [SEG-1:0]    seg_a [STAGES];
    logic [SEG-1:0]    seg_b [STAGES];
    logic [SEG-1:0]    seg_s [STAGES];
    logic [STAGES-1:0] seg_ci;
    logic [STAGES-1:0] seg_co;
    logic [STAGES-1:0] seg_cmsb;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg_a[k]  = a[SEG-1:0];
            assign seg_b[k]  = b[SEG-1:0];
            assign seg_ci[k] = carry_i;
        end else begin : g_next
            assign seg_a[k]  = st_q[k-1].a[k*SEG +: SEG];
            assign seg_b[k]  = st_q[k-1].b[k*SEG +: SEG];
            assign seg_ci[k] = st_q[k-1].ctl.carry;
        end

        adder_seg #(.SEG(SEG)) u_seg (
            .a           (seg_a[k]),
            .b           (seg_b[k]),
            .carry_i     (seg_ci[k]),
            .sum         (seg_s[k]),
            .carry_o     (seg_co[k]),
            .carry_msb_o (seg_cmsb[k])
        );
    end

    always_comb begin
        adv  = ready_i | ~st_q[STAGES-1].ctl.valid;
        // NOTE: default every stage to hold so no path leaves st_d unassigned
        // (which would infer latches); advancing overrides it below.
        st_d = st_q;
        if (adv) begin
            st_d[0].ctl.valid = valid_i;
            st_d[0].ctl.carry = seg_co[0];
            st_d[0].sum       = WIDTH'(seg_s[0]);
            st_d[0].a         = a;
            st_d[0].b         = b;
            for (int k = 1; k < STAGES; k++) begin
                st_d[k]                    = st_q[k-1];
                st_d[k].ctl.carry          = seg_co[k];
                st_d[k].sum[k*SEG +: SEG]  = seg_s[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data fields are reset as well as valid bits, so sum and
            // carry_o read 0 after reset instead of leftover operands.
            for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
        end
    end

    assign ready_o = adv;
    assign valid_o = st_q[STAGES-1].ctl.valid;
    assign sum     = st_q[STAGES-1].sum;
    assign carry_o = st_q[STAGES-1].ctl.carry;

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: carry into the top bit differs from the carry out of it.
    always_comb ovf_d = adv ? (seg_cmsb[STAGES-1] ^ seg_co[STAGES-1]) : ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign overflow_o = ovf_q;
`endif

    // Final-stage operand copies and lower msb-carries have no consumer.
    logic unused_fold;
    assign unused_fold = ^{st_q[STAGES-1].a, st_q[STAGES-1].b, seg_cmsb};

endmodule
